spi_slave_ram: RTL and testbench
================================

// Module: spi_slave_ram
// PURPOSE
// - Single-port RAM that sits directly downstream of the SPI slave and consumes its parallel words.
// - Decodes the 10-bit rx_data word {cmd[1:0], payload[7:0]} into write-address, write-data,
//   read-address and read-data operations.
// - Returns read bytes upstream on dout/tx_valid, which feed the slave's tx_data/tx_valid for MISO shift-out.
// PARAMETERS
// - MEM_DEPTH  256  number of 8-bit words; must equal 2**ADDR_SIZE
// - ADDR_SIZE  8    address width, <= 8; uses payload[ADDR_SIZE-1:0], upper payload bits ignored
// - AUTO_INC   0    1: post-increment wr_addr after each write-data, rd_addr after each read-data
// PORTS
// - clk       input   1   system clock, rising edge
// - rst_n     input   1   asynchronous active-low reset
// - din       input   10  command word from SPI slave rx_data: din[9:8]=cmd, din[7:0]=payload
// - rx_valid  input   1   din valid this cycle; one command accepted per cycle it is high
// - dout      output  8   read data to SPI slave tx_data
// - tx_valid  output  1   dout holds valid read data
// BEHAVIOUR
// Interface:
// - One clock (clk); reset rst_n is asynchronous, active-low.
// - All outputs are registered.
// Reset:
// - Asynchronously clears dout=8'h00, tx_valid=0, wr_addr=0, rd_addr=0.
// - RAM array is NOT reset and contents survive reset.
// - Reset mid-operation aborts any pending read; tx_valid drops immediately.
// Command decode (only when rx_valid=1, evaluated at clk rising edge):
// - 2'b00 write-address: wr_addr <= payload.
// - 2'b01 write-data: mem[wr_addr] <= payload; if AUTO_INC, wr_addr <= wr_addr+1.
// - 2'b10 read-address: rd_addr <= payload.
// - 2'b11 read-data: dout <= mem[rd_addr] and tx_valid <= 1, both visible 1 cycle after the accepting edge;
//   payload is ignored; if AUTO_INC, rd_addr <= rd_addr+1.
// tx_valid hold rule:
// - Once set, tx_valid and dout hold until the next accepted command.
// - Next command != 2'b11 -> tx_valid <= 0 and dout holds its last value.
// - Next command == 2'b11 -> tx_valid stays 1 and dout updates to the new word (back-to-back reads, no gap).
// - rx_valid=0 -> all registers hold.
// Boundary conditions:
// - Address increment wraps modulo MEM_DEPTH (e.g. 8'hFF -> 8'h00).
// - Read-data with no prior read-address reads mem[rd_addr] (0 after reset); not an error.
// - Read-data from an address never written returns the array content (X in simulation);
//   the bench must not check it.
// - Write then read of the same address on consecutive cycles returns the new data,
//   since the write completes before the read edge.
// - Writes are never visible on dout until a read-data command is issued.
// TESTING
// - Reset: rst_n=0 mid-stream -> dout=8'h00, tx_valid=0 asynchronously; a prior write to 8'h10 is still readable after reset.
// - Write/read: 10'h010, 10'h1A5, 10'h210, 10'h300 -> next cycle dout=8'hA5, tx_valid=1; tx_valid holds with rx_valid=0.
// - Drop: after the read above, 10'h0FF accepted -> tx_valid=0 next cycle, dout stays 8'hA5.
// - Back-to-back reads, AUTO_INC=1: write 8'h11,8'h22 at 8'hFE,8'hFF; 10'h2FE then 10'h3xx twice
//   -> dout 8'h11 then 8'h22, tx_valid continuous; rd_addr wraps to 8'h00.
// - Write-address wrap, AUTO_INC=1: 10'h0FF, 10'h155, 10'h166 -> mem[FF]=55, mem[00]=66.
// - Idle gaps: rx_valid low for 5 cycles between commands -> no state change.
//   Repeat with AUTO_INC=0 -> addresses never change without an address command.

Source files
------------

// File: rtl/spi_slave_ram.sv
// spi_slave_ram: single-port 8-bit RAM fed by the SPI slave's parallel rx words.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   din      - {cmd[1:0], payload[7:0]} from the SPI slave rx_data
//   rx_valid - din valid; one command accepted per cycle high
//   dout     - read data toward the SPI slave tx_data (registered)
//   tx_valid - dout holds valid read data (registered)
// Commands: 00 set wr_addr, 01 write data, 10 set rd_addr, 11 read data.
module spi_slave_ram #(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned AUTO_INC  = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] din,
   input  logic       rx_valid,
   output logic [7:0] dout,
   output logic       tx_valid
);

   localparam int unsigned DATA_W = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   logic [DATA_W-1:0]    mem [MEM_DEPTH];

   logic [ADDR_SIZE-1:0] wr_addr, wr_addr_nxt;
   logic [ADDR_SIZE-1:0] rd_addr, rd_addr_nxt;
   logic [DATA_W-1:0]    dout_nxt;
   logic                 tx_valid_nxt;
   logic                 mem_we;

   logic [1:0]           cmd;
   logic [DATA_W-1:0]    payload;
   logic [ADDR_SIZE-1:0] payload_addr;

   assign cmd          = din[9:8];
   assign payload      = din[7:0];
   assign payload_addr = din[ADDR_SIZE-1:0];

   // Command decode; everything holds while rx_valid is low.
   always_comb begin
      wr_addr_nxt  = wr_addr;
      rd_addr_nxt  = rd_addr;
      dout_nxt     = dout;
      tx_valid_nxt = tx_valid;
      mem_we       = 1'b0;
      if (rx_valid) begin
         // Any accepted non-read command ends a held read; dout keeps its value.
         tx_valid_nxt = 1'b0;
         case (cmd)
            CMD_WR_ADDR: wr_addr_nxt = payload_addr;
            CMD_WR_DATA: begin
               mem_we = 1'b1;
               if (AUTO_INC != 0) wr_addr_nxt = wr_addr + ADDR_SIZE'(1);
            end
            CMD_RD_ADDR: rd_addr_nxt = payload_addr;
            CMD_RD_DATA: begin
               dout_nxt     = mem[rd_addr];
               tx_valid_nxt = 1'b1;
               if (AUTO_INC != 0) rd_addr_nxt = rd_addr + ADDR_SIZE'(1);
            end
            default: ;
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr  <= '0;
         rd_addr  <= '0;
         dout     <= '0;
         tx_valid <= 1'b0;
      end else begin
         wr_addr  <= wr_addr_nxt;
         rd_addr  <= rd_addr_nxt;
         dout     <= dout_nxt;
         tx_valid <= tx_valid_nxt;
      end
   end

   // RAM array is intentionally not reset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_addr] <= payload;
   end

endmodule

// File: tb/tb_spi_slave_ram.sv
// tb_spi_slave_ram: directed bench for spi_slave_ram, one instance with
// AUTO_INC=0 (u=0) and one with AUTO_INC=1 (u=1). Expected read bytes come
// from a behavioural memory model and flow through a scoreboard queue.
module tb_spi_slave_ram;

   typedef struct {
      logic [7:0] data;
      bit         known;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [9:0] din0, din1;
   logic       rx_valid0, rx_valid1;
   logic [7:0] dout0, dout1;
   logic       tx_valid0, tx_valid1;

   int checks   = 0;
   int failures = 0;

   exp_t       sb_q[$];
   logic [7:0] m_mem   [2][256];
   bit         m_known [2][256];
   logic [7:0] m_wr    [2];
   logic [7:0] m_rd    [2];
   logic [7:0] m_dout  [2];
   bit         m_dknown[2];
   logic       m_tv    [2];

   spi_slave_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .din(din0), .rx_valid(rx_valid0),
      .dout(dout0), .tx_valid(tx_valid0));

   spi_slave_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .din(din1), .rx_valid(rx_valid1),
      .dout(dout1), .tx_valid(tx_valid1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare both instances' outputs against the model's held state.
   task automatic check_outputs(input string tag);
      check({tag, " u0 tx_valid"}, {7'd0, tx_valid0}, {7'd0, m_tv[0]});
      check({tag, " u1 tx_valid"}, {7'd0, tx_valid1}, {7'd0, m_tv[1]});
      if (m_dknown[0]) check({tag, " u0 dout"}, dout0, m_dout[0]);
      if (m_dknown[1]) check({tag, " u1 dout"}, dout1, m_dout[1]);
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_wr[u]     = 8'h00;
         m_rd[u]     = 8'h00;
         m_dout[u]   = 8'h00;
         m_dknown[u] = 1'b1;
         m_tv[u]     = 1'b0;
      end
      sb_q.delete();
   endtask

   // Drive one command into instance u, update the model, check after the edge.
   task automatic send(input int u, input logic [9:0] w, input string tag);
      exp_t e;
      @(negedge clk);
      rx_valid0 = 1'b0;
      rx_valid1 = 1'b0;
      if (u == 0) begin din0 = w; rx_valid0 = 1'b1; end
      else        begin din1 = w; rx_valid1 = 1'b1; end
      m_tv[u] = 1'b0;
      case (w[9:8])
         2'b00: m_wr[u] = w[7:0];
         2'b01: begin
            m_mem[u][m_wr[u]]   = w[7:0];
            m_known[u][m_wr[u]] = 1'b1;
            if (u == 1) m_wr[u] = m_wr[u] + 8'd1;
         end
         2'b10: m_rd[u] = w[7:0];
         default: begin
            e.data  = m_mem[u][m_rd[u]];
            e.known = m_known[u][m_rd[u]];
            sb_q.push_back(e);
            m_tv[u] = 1'b1;
            if (u == 1) m_rd[u] = m_rd[u] + 8'd1;
         end
      endcase
      @(posedge clk);
      #1;
      if (w[9:8] == 2'b11) begin
         checks++;
         assert (sb_q.size() > 0) else begin
            failures++;
            $error("FAIL %s scoreboard observed=empty expected=entry", tag);
         end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            m_dout[u]   = e.data;
            m_dknown[u] = e.known;
         end
      end
      check_outputs(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid0 = 1'b0;
         rx_valid1 = 1'b0;
         din0 = 10'h3FF;
         din1 = 10'h3FF;
         @(posedge clk);
         #1;
         check_outputs(tag);
      end
   endtask

   initial begin
      for (int u = 0; u < 2; u++)
         for (int a = 0; a < 256; a++) m_known[u][a] = 1'b0;
      rst_n = 1'b0; din0 = '0; din1 = '0; rx_valid0 = 1'b0; rx_valid1 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write/read, hold, then drop on a non-read command.
      send(0, 10'h010, "wa10");
      send(0, 10'h1A5, "wdA5");
      send(0, 10'h210, "ra10");
      send(0, 10'h300, "rd10");
      check("rd10 literal", dout0, 8'hA5);
      idle(3, "hold");
      send(0, 10'h0FF, "drop");
      check("drop literal", dout0, 8'hA5);

      // Write then read of same address on consecutive edges.
      send(0, 10'h230, "ra30");
      send(0, 10'h030, "wa30");
      send(0, 10'h1BB, "wdBB");
      send(0, 10'h300, "rd30");
      check("wr_rd literal", dout0, 8'hBB);

      // Seed mem[00] for the post-reset default read.
      send(0, 10'h000, "wa00");
      send(0, 10'h1C3, "wdC3");

      // Idle gaps, AUTO_INC=0: address registers stay put.
      send(0, 10'h020, "u0 wa20");
      send(0, 10'h144, "u0 wd44");
      idle(5, "u0 gap1");
      send(0, 10'h145, "u0 wd45");
      send(0, 10'h220, "u0 ra20");
      send(0, 10'h300, "u0 rd20a");
      idle(5, "u0 gap2");
      send(0, 10'h300, "u0 rd20b");
      check("noinc literal", dout0, 8'h45);

      // Mid-stream reset right after a read: outputs clear asynchronously.
      send(0, 10'h300, "pre-reset rd");
      @(negedge clk);
      rx_valid0 = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("async reset");
      @(posedge clk);
      #1;
      check_outputs("in reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Contents survive reset; default rd_addr is 0.
      send(0, 10'h3AA, "rd default");
      check("rd default literal", dout0, 8'hC3);
      send(0, 10'h210, "ra10 post");
      send(0, 10'h300, "rd10 post");
      check("survive literal", dout0, 8'hA5);

      // AUTO_INC=1: write-address wrap.
      send(1, 10'h0FF, "u1 waFF");
      send(1, 10'h155, "u1 wd55");
      send(1, 10'h166, "u1 wd66");
      send(1, 10'h2FF, "u1 raFF");
      send(1, 10'h300, "u1 rdFF");
      check("wrap FF literal", dout1, 8'h55);
      send(1, 10'h300, "u1 rd00");
      check("wrap 00 literal", dout1, 8'h66);

      // Back-to-back reads with rd_addr wrap.
      send(1, 10'h0FE, "u1 waFE");
      send(1, 10'h111, "u1 wd11");
      send(1, 10'h122, "u1 wd22");
      send(1, 10'h2FE, "u1 raFE");
      send(1, 10'h300, "u1 b2b1");
      check("b2b1 literal", dout1, 8'h11);
      send(1, 10'h3FF, "u1 b2b2");
      check("b2b2 literal", dout1, 8'h22);
      check("b2b2 tv literal", {7'd0, tx_valid1}, 8'h01);
      send(1, 10'h300, "u1 b2b3");
      check("rd wrap literal", dout1, 8'h66);

      // Idle gaps, AUTO_INC=1.
      send(1, 10'h020, "u1 wa20");
      send(1, 10'h144, "u1 wd44");
      idle(5, "u1 gap1");
      send(1, 10'h145, "u1 wd45");
      send(1, 10'h220, "u1 ra20");
      send(1, 10'h300, "u1 rd20");
      idle(5, "u1 gap2");
      send(1, 10'h300, "u1 rd21");
      check("inc literal", dout1, 8'h45);
      idle(2, "tail");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
